// File: rtl/riscv_run_ctrl_pkg.sv
// Shared definitions for the run controller: command encodings, controller states
// and default memory geometry / halt instruction.
package riscv_run_ctrl_pkg;

    localparam int          IMEM_AW_DEF    = 8;
    localparam logic [31:0] HALT_INSTR_DEF = 32'h00100073;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_HALT = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLR,
        ST_RUN,
        ST_STEP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/riscv_prog_loader.sv
// Streams program words into instruction memory while the controller is in LOAD,
// with a write-address counter and detection of the last addressable word.
module riscv_prog_loader
    import riscv_run_ctrl_pkg::*;
#(
    parameter int IMEM_AW = IMEM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               start,
    input  logic               ld_valid,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               finish,
    output logic               overflow
);

    localparam logic [IMEM_AW-1:0] ADDR_MAX = '1;

    logic [IMEM_AW-1:0] addr_reg;
    logic [IMEM_AW-1:0] addr_next;
    logic               beat;
    logic               at_end;

    assign beat       = active && ld_valid;
    assign at_end     = (addr_reg == ADDR_MAX);
    assign ld_ready   = active;
    assign imem_we    = beat;
    assign imem_waddr = addr_reg;
    assign imem_wdata = ld_data;
    assign finish     = beat && (ld_last || at_end);
    // Filling the last word without ld_last ends the load; nothing wraps to 0.
    assign overflow   = beat && !ld_last && at_end;

    always_comb begin
        addr_next = addr_reg;
        if (start) begin
            addr_next = '0;
        end else if (beat) begin
            addr_next = addr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
        end else begin
            addr_reg <= addr_next;
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for a small RISC-V core: program loading, budgeted or unlimited
// runs, single-stepping, and cycle counting, driven by a simple command port.
module riscv_run_ctrl
    import riscv_run_ctrl_pkg::*;
#(
    parameter int          IMEM_AW    = IMEM_AW_DEF,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [31:0]        cmd_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               core_rst,
    output logic               core_en,
    input  logic [31:0]        core_instr,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        cycle_cnt
);

    state_e      state_reg, state_next;
    logic [31:0] budget_reg, budget_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        err_reg, err_next;
    logic [31:0] cnt_inc;
    logic        load_start;
    logic        load_active;
    logic        load_finish;
    logic        load_overflow;
    logic        halt_fetched;
    cmd_op_e     op;

    assign op           = cmd_op_e'(cmd_op);
    assign halt_fetched = (core_instr == HALT_INSTR);
    assign cnt_inc      = (cnt_reg == 32'hFFFF_FFFF) ? cnt_reg : cnt_reg + 32'd1;
    assign load_active  = (state_reg == ST_LOAD) && !rst;

    riscv_prog_loader #(
        .IMEM_AW (IMEM_AW)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .active     (load_active),
        .start      (load_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .finish     (load_finish),
        .overflow   (load_overflow)
    );

    always_comb begin
        state_next  = state_reg;
        budget_next = budget_reg;
        cnt_next    = cnt_reg;
        err_next    = err_reg;
        cmd_ready   = 1'b0;
        core_en     = 1'b0;
        core_rst    = rst;
        done        = 1'b0;
        load_start  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (op)
                        OP_LOAD: begin
                            state_next = ST_LOAD;
                            load_start = 1'b1;
                            err_next   = 1'b0;
                        end
                        OP_RUN: begin
                            state_next  = ST_CLR;
                            budget_next = cmd_data;
                        end
                        OP_STEP: state_next = ST_STEP;
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (load_finish) begin
                    state_next = ST_IDLE;
                end
                if (load_overflow) begin
                    err_next = 1'b1;
                end
            end
            ST_CLR: begin
                core_rst   = 1'b1;
                cnt_next   = '0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                cmd_ready = 1'b1;
                if (cmd_valid && op != OP_HALT) begin
                    err_next = 1'b1;
                end
                // EBREAK outranks a HALT command, which outranks the budget.
                if (halt_fetched) begin
                    state_next = ST_DONE;
                end else if (cmd_valid && op == OP_HALT) begin
                    state_next = ST_DONE;
                end else begin
                    core_en  = 1'b1;
                    cnt_next = cnt_inc;
                    if (budget_reg != '0 && cnt_reg == budget_reg - 32'd1) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_STEP: begin
                if (halt_fetched) begin
                    state_next = ST_DONE;
                end else begin
                    core_en    = 1'b1;
                    cnt_next   = cnt_inc;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (rst) begin
            cmd_ready  = 1'b0;
            core_en    = 1'b0;
            done       = 1'b0;
            load_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            budget_reg <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            budget_reg <= budget_next;
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
        end
    end

    assign busy      = (state_reg != ST_IDLE) && !rst;
    assign err       = err_reg;
    assign cycle_cnt = cnt_reg;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Randomized self-checking bench: a stand-in core (PC + memory) and a
// transaction-level model of loads, runs and steps.
module tb_riscv_run_ctrl;
    import riscv_run_ctrl_pkg::*;

    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        core_en;
    logic [31:0] core_instr;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    riscv_run_ctrl #(
        .IMEM_AW    (8),
        .HALT_INSTR (32'h00100073)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .core_instr (core_instr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory written through the DUT port, and a trivial core.
    bit [31:0] imem [256];
    logic [7:0] pc = '0;
    int en_total = 0;
    int crst_total = 0;
    int done_total = 0;
    int wr_total = 0;
    int stray_total = 0;
    int        wr_addr_log [1024];
    bit [31:0] wr_data_log [1024];

    assign core_instr = imem[pc];

    always @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
            wr_addr_log[wr_total % 1024] <= int'(imem_waddr);
            wr_data_log[wr_total % 1024] <= imem_wdata;
            wr_total <= wr_total + 1;
            if (!(ld_valid && ld_ready)) stray_total <= stray_total + 1;
        end
        if (core_rst) pc <= '0;
        else if (core_en) pc <= pc + 8'd1;
        if (core_en) en_total <= en_total + 1;
        if (core_rst) crst_total <= crst_total + 1;
        if (done) done_total <= done_total + 1;
    end

    // Model state: what the bench believes memory, PC, counter and err hold.
    bit [31:0] exp_mem [256];
    bit [31:0] ld_words [256];
    int        exp_pc = 0;
    logic [31:0] exp_cnt = '0;
    logic      exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] rand_addi();
        bit [31:0] r;
        r = $urandom;
        return {r[31:20], r[19:15], 3'b000, r[11:7], 7'h13};
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] data);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        #1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("cmd_accept_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input int n, input bit use_last);
        int i;
        int guard;
        int wr0;
        wr0 = wr_total;
        send_cmd(OP_LOAD, 32'd0);
        i = 0;
        guard = 0;
        while (i < n && guard < 5000) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = ld_words[i];
            ld_last  = use_last && (i == n - 1);
            #1;
            if (ld_valid && ld_ready) i++;
            @(negedge clk);
            guard++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("load_timeout", 32'(i), 32'(n));
        for (int k = 0; k < n; k++) exp_mem[k] = ld_words[k];
        exp_err = !use_last;
        repeat (3) @(negedge clk);
        check("load_busy", 32'(busy), 32'd0);
        check("load_nwrites", 32'(wr_total - wr0), 32'(n));
        check("load_err", 32'(err), 32'(exp_err));
        for (int k = 0; k < n; k++) begin
            check("load_addr", 32'(wr_addr_log[(wr0 + k) % 1024]), 32'(k));
            check("load_data", wr_data_log[(wr0 + k) % 1024], ld_words[k]);
        end
        $display("LOAD words=%0d last=%0d err=%0d", n, use_last, err);
    endtask

    // Enabled cycles = earliest of: EBREAK position, nonzero budget, HALT point.
    task automatic do_run(input logic [31:0] b, input int h, input bit want_step);
        int eb;
        int en;
        int s;
        int en0;
        int r0;
        int d0;
        int cyc;
        bit hs;
        bit ss;
        eb = -1;
        for (int a = 0; a < 256; a++) begin
            if (exp_mem[a] == EBREAK) begin
                eb = a;
                break;
            end
        end
        en = 1 << 30;
        if (eb >= 0) en = eb;
        if (b != 0 && int'(b) < en) en = int'(b);
        if (h >= 0 && h < en) en = h;
        s = (want_step && en >= 1) ? int'($urandom_range(0, en - 1)) : -1;
        en0 = en_total;
        r0  = crst_total;
        d0  = done_total;
        send_cmd(OP_RUN, b);
        cyc = 0;
        hs = 1'b0;
        ss = 1'b0;
        while (busy && cyc < 1000) begin
            cmd_valid = 1'b0;
            if (cmd_ready && !hs && h >= 0 && cycle_cnt == 32'(h)) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_HALT;
                hs = 1'b1;
            end else if (cmd_ready && !ss && s >= 0 && cycle_cnt == 32'(s)) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_STEP;
                ss = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        if (s >= 0) exp_err = 1'b1;
        exp_cnt = 32'(en);
        exp_pc  = en % 256;
        check("run_timeout", 32'(cyc < 1000), 32'd1);
        check("run_core_en_cycles", 32'(en_total - en0), 32'(en));
        check("run_core_rst_pulses", 32'(crst_total - r0), 32'd1);
        check("run_done_pulses", 32'(done_total - d0), 32'd1);
        check("run_cycle_cnt", cycle_cnt, exp_cnt);
        check("run_err", 32'(err), 32'(exp_err));
        $display("RUN budget=%0d halt_at=%0d step_at=%0d ebreak=%0d cycles=%0d err=%0d",
                 b, h, s, eb, cycle_cnt, err);
    endtask

    task automatic do_step();
        bit at_eb;
        int en0;
        int r0;
        int d0;
        int n;
        at_eb = (exp_mem[exp_pc] == EBREAK);
        en0 = en_total;
        r0  = crst_total;
        d0  = done_total;
        send_cmd(OP_STEP, 32'd0);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!at_eb) begin
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            exp_pc = (exp_pc + 1) % 256;
        end
        check("step_timeout", 32'(n < 20), 32'd1);
        check("step_core_en", 32'(en_total - en0), at_eb ? 32'd0 : 32'd1);
        check("step_done", 32'(done_total - d0), at_eb ? 32'd1 : 32'd0);
        check("step_no_core_rst", 32'(crst_total - r0), 32'd0);
        check("step_cycle_cnt", cycle_cnt, exp_cnt);
        $display("STEP ebreak=%0d cycles=%0d", at_eb, cycle_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int wr0;
        // Reset behaviour
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_core_rst", 32'(core_rst), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        $display("RESET done");

        // Full memory without ld_last: overflow, no wrap write
        for (int k = 0; k < 256; k++) ld_words[k] = rand_addi();
        do_load(256, 1'b0);
        wr0 = wr_total;
        repeat (5) @(negedge clk);
        check("overflow_no_wrap_write", 32'(wr_total - wr0), 32'd0);

        // Budgeted run over ADDI stream; err stays sticky
        do_run(32'd5, -1, 1'b0);

        // Three-word program ending in EBREAK
        ld_words[0] = 32'h00500093;
        ld_words[1] = 32'h00308113;
        ld_words[2] = 32'h00100073;
        do_load(3, 1'b1);
        do_run(32'd0, -1, 1'b0);

        // Unlimited run stopped by HALT, with a stray STEP
        for (int k = 0; k < 8; k++) ld_words[k] = rand_addi();
        do_load(8, 1'b1);
        do_run(32'd0, 10, 1'b1);

        // Reset on the third RUN cycle, then a single step
        for (int k = 0; k < 4; k++) ld_words[k] = rand_addi();
        do_load(4, 1'b1);
        d0 = done_total;
        send_cmd(OP_RUN, 32'd0);
        n = 0;
        while (!(cmd_ready && cycle_cnt == 32'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_run_reach", 32'(n < 50), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_run_busy", 32'(busy), 32'd0);
        check("rst_run_cycle_cnt", cycle_cnt, 32'd0);
        rst = 1'b0;
        exp_pc  = 0;
        exp_cnt = '0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_run_idle", 32'(busy), 32'd0);
        check("rst_run_no_done", 32'(done_total - d0), 32'd0);
        $display("RESET mid-run cycles=%0d", cycle_cnt);
        do_step();

        // Randomized programs, runs and steps
        for (int it = 0; it < 12; it++) begin
            int len;
            int ebp;
            int h;
            logic [31:0] b;
            len = $urandom_range(4, 40);
            ebp = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int k = 0; k < len; k++) ld_words[k] = (k == ebp) ? EBREAK : rand_addi();
            do_load(len, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) do_step();
            end else begin
                b = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'($urandom_range(1, 30));
                h = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 30)) : -1;
                if (b == 0 && h < 0) h = $urandom_range(0, 30);
                do_run(b, h, $urandom_range(0, 1) != 0);
                if ($urandom_range(0, 1) != 0) do_step();
            end
        end

        check("stray_writes", 32'(stray_total), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
